id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of the register file. Captures readData1/2 plus decoded
//  fields each clock_in edge, refreshes operands against same-cycle WB writes, detects load-use hazards
//  and inserts bubbles; supports stall (hold) and flush (squash). Feeds the EX stage (ALU, fwd unit).
// PARAMETERS
//  DATA_W  32  width of operands, PC+4, immediate
//  REG_AW  5   register index width
//  CTRL_W  9   packed control: [0]regWrite [1]memToReg [2]memRead [3]memWrite [4]branch [5]aluSrc
//              [6]regDst [8:7]aluOp
// PORTS
//  clock_in      in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  stall         in   1       hold all ex_* contents (downstream wait)
//  flush         in   1       squash: load bubble next edge
//  id_valid      in   1       ID stage holds a real instruction
//  id_ctrl       in   CTRL_W  decoded control
//  id_pc4        in   DATA_W  PC+4
//  id_readData1  in   DATA_W  register file port 1 data (rs)
//  id_readData2  in   DATA_W  register file port 2 data (rt)
//  id_rs, id_rt, id_rd in REG_AW  source/dest indices
//  id_imm        in   DATA_W  sign-extended immediate
//  wb_regWrite   in   1       WB stage writes the register file this cycle
//  wb_writeReg   in   REG_AW  WB destination index
//  wb_writeData  in   DATA_W  WB write data
//  ex_valid      out  1       registered valid
//  ex_ctrl, ex_pc4, ex_readData1, ex_readData2, ex_rs, ex_rt, ex_rd, ex_imm  out  registered copies
//  hazard_stall  out  1       combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset: ex_valid=0, every ex_* output=0 (ctrl=0 is a NOP); takes effect on the edge reset is sampled high.
//  - hazard_stall = id_valid & ex_valid & ex_ctrl[2] & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt) & ~flush.
//  - Per-edge priority: reset > flush > stall > hazard_stall > load.
//    flush: ex_valid=0, ex_ctrl=0; data fields don't-care (drive 0).
//    stall: all ex_* held (except operand refresh below); hazard_stall output still computed, is ignored here.
//    hazard_stall: bubble loaded (ex_valid=0, ex_ctrl=0); ID instruction re-presented next cycle.
//    load: ex_* <= id_* ; ex_valid <= id_valid; ex_ctrl <= id_valid ? id_ctrl : 0.
//  - Latency: 1 cycle ID->EX. No combinational path id_* -> ex_*; hazard_stall is the only comb output.
//  - Register 0: never bypassed/refreshed; an index of 0 always carries captured data unchanged.
//  - Simultaneous flush+stall: flush wins. reset mid-stall: cleared, stall ignored that edge.
//  - Bubble inserted while hazard persists only for one cycle, since bubble clears ex_ctrl[2].
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   - load: if wb_regWrite & wb_writeReg!=0 & wb_writeReg==id_rs, ex_readData1<=wb_writeData (same for rt/2).
//   - stall: if wb_regWrite & wb_writeReg!=0 matches held ex_rs/ex_rt, that operand refreshed to
//     wb_writeData while other fields hold; prevents stale operands after a long stall.
//  WB_BYPASS_EN undefined: operands captured verbatim from id_readData1/2 and strictly held in stall;
//   register file must be write-before-read in the same cycle.
// TESTING
//  1 reset=1 one edge with all inputs nonzero -> all ex_*=0, ex_valid=0; deassert, load id_valid=1,
//    id_readData1=32'hFFFF0000 -> next edge ex_readData1=32'hFFFF0000, ex_valid=1.
//  2 ex holds lw (ctrl[2]=1, ex_rt=5'd10), ID has id_rs=10 -> hazard_stall=1; next edge ex_valid=0,
//    ex_ctrl=0; following edge ID instr loads, hazard_stall=0.
//  3 same as 2 but ex_rt=0 and id_rs=0 -> hazard_stall=0, normal load.
//  4 stall=1 for 3 edges -> ex_* unchanged; assert flush=1 with stall=1 -> ex_valid=0, ex_ctrl=0.
//  5 WB_BYPASS_EN: id_rs=5'b10101, id_readData1=0, wb_regWrite=1, wb_writeReg=5'b10101,
//    wb_writeData=32'hFFFF0000 -> ex_readData1=32'hFFFF0000; undefined -> 0; same with writeReg=0 -> 0.
//  6 WB_BYPASS_EN: stall=1, ex_rt=5'b01010, WB writes 32'h0000FFFF to 10 -> ex_readData2=32'h0000FFFF,
//    other fields held; undefined -> ex_readData2 unchanged.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus.
// Groups the ID-side capture inputs, the WB write port, the pipeline controls
// and the registered EX-side outputs into one bundle.
// The master modport belongs to the surrounding pipeline, which drives ID, WB and the controls.
// The slave modport belongs to the pipeline register.
// The width parameters must match the ones given to id_ex_pipe_reg.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9
);
    // Pipeline controls
    logic              stall;
    logic              flush;

    // ID stage capture inputs
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_readData1;
    logic [DATA_W-1:0] id_readData2;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_imm;

    // WB stage register-file write port, observed for operand refresh
    logic              wb_regWrite;
    logic [REG_AW-1:0] wb_writeReg;
    logic [DATA_W-1:0] wb_writeData;

    // Registered EX stage outputs
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_readData1;
    logic [DATA_W-1:0] ex_readData2;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_imm;

    // Combinational load-use hazard request back to PC and IF/ID
    logic              hazard_stall;

    modport master (
        output stall, flush,
        output id_valid, id_ctrl, id_pc4, id_readData1, id_readData2,
        output id_rs, id_rt, id_rd, id_imm,
        output wb_regWrite, wb_writeReg, wb_writeData,
        input  ex_valid, ex_ctrl, ex_pc4, ex_readData1, ex_readData2,
        input  ex_rs, ex_rt, ex_rd, ex_imm,
        input  hazard_stall
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_ctrl, id_pc4, id_readData1, id_readData2,
        input  id_rs, id_rt, id_rd, id_imm,
        input  wb_regWrite, wb_writeReg, wb_writeData,
        output ex_valid, ex_ctrl, ex_pc4, ex_readData1, ex_readData2,
        output ex_rs, ex_rt, ex_rd, ex_imm,
        output hazard_stall
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register that sits directly after the register file.
//
// What it does:
//  - It captures the ID instruction on each rising clock_in edge.
//  - It inserts a bubble on a load-use hazard.
//  - It holds its contents on stall.
//  - It squashes its contents on flush.
//
// Optional feature: define WB_BYPASS_EN to refresh operands from the WB write port.
//  - With the macro undefined, operands are taken verbatim from the register file.
//  - With the macro undefined, a stall holds the operands strictly.
//
// Flow control:
//  - ex_valid qualifies the EX-side contents.
//  - stall is the downstream "not ready" signal. While stall is high, nothing new is accepted and ex_* holds.
//  - hazard_stall is this block's own "not ready" towards IF/ID.
//  - While hazard_stall is high, the ID instruction is not consumed and must be re-presented.
//  - Edge priority is: reset > flush > stall > hazard bubble > load.
//
// Register index 0 is hard-wired zero. It is never matched for hazards or bypass.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9
) (
    input  logic               clock_in,
    input  logic               reset,
    id_ex_pipe_reg_if.slave    bus
);
    // ctrl[2] is memRead: an instruction in EX with this bit set is a load
    localparam int MEM_READ_BIT = 2;

    logic [DATA_W-1:0] load_data1;
    logic [DATA_W-1:0] load_data2;
    logic [DATA_W-1:0] hold_data1;
    logic [DATA_W-1:0] hold_data2;

    // Load-use detection: a valid load in EX whose destination is read by the ID instruction
    always_comb begin
        bus.hazard_stall = bus.id_valid & bus.ex_valid & bus.ex_ctrl[MEM_READ_BIT]
                         & (bus.ex_rt != '0)
                         & ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt))
                         & ~bus.flush;
    end

`ifdef WB_BYPASS_EN
    logic wb_live;
    assign wb_live = bus.wb_regWrite & (bus.wb_writeReg != '0);

    // Operand selection with WB refresh, for both the load path and the stall-hold path
    always_comb begin
        load_data1 = bus.id_readData1;
        load_data2 = bus.id_readData2;
        hold_data1 = bus.ex_readData1;
        hold_data2 = bus.ex_readData2;
        if (wb_live && (bus.wb_writeReg == bus.id_rs)) load_data1 = bus.wb_writeData;
        if (wb_live && (bus.wb_writeReg == bus.id_rt)) load_data2 = bus.wb_writeData;
        if (wb_live && (bus.wb_writeReg == bus.ex_rs)) hold_data1 = bus.wb_writeData;
        if (wb_live && (bus.wb_writeReg == bus.ex_rt)) hold_data2 = bus.wb_writeData;
    end
`else
    // The WB port is not observed here. The register file must write before it reads within a cycle.
    logic unused_wb;
    assign unused_wb = &{1'b0, bus.wb_regWrite, bus.wb_writeReg, bus.wb_writeData};

    // Operands pass through verbatim on load and are held unchanged on stall
    always_comb begin
        load_data1 = bus.id_readData1;
        load_data2 = bus.id_readData2;
        hold_data1 = bus.ex_readData1;
        hold_data2 = bus.ex_readData2;
    end
`endif

    // Pipeline register update with reset > flush > stall > hazard bubble > load priority
    always_ff @(posedge clock_in) begin
        if (reset || bus.flush || (!bus.stall && bus.hazard_stall)) begin
            // Reset, squash and bubble all present a NOP. Data fields are zeroed.
            bus.ex_valid     <= 1'b0;
            bus.ex_ctrl      <= '0;
            bus.ex_pc4       <= '0;
            bus.ex_readData1 <= '0;
            bus.ex_readData2 <= '0;
            bus.ex_rs        <= '0;
            bus.ex_rt        <= '0;
            bus.ex_rd        <= '0;
            bus.ex_imm       <= '0;
        end else if (bus.stall) begin
            // Hold everything. Only the operands may be refreshed.
            bus.ex_readData1 <= hold_data1;
            bus.ex_readData2 <= hold_data2;
        end else begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_ctrl      <= bus.id_valid ? bus.id_ctrl : '0;
            bus.ex_pc4       <= bus.id_pc4;
            bus.ex_readData1 <= load_data1;
            bus.ex_readData2 <= load_data2;
            bus.ex_rs        <= bus.id_rs;
            bus.ex_rt        <= bus.id_rt;
            bus.ex_rd        <= bus.id_rd;
            bus.ex_imm       <= bus.id_imm;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg. It uses directed, table-driven vectors.
// Each vector is driven at the falling edge.
// hazard_stall is checked just before the next rising edge.
// The registered outputs are checked 1ns after that rising edge.
// Expectations for the operand-refresh cases follow WB_BYPASS_EN.
module tb_id_ex_pipe_reg;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    id_ex_pipe_reg_if bus ();

    id_ex_pipe_reg dut (
        .clock_in (clk),
        .reset    (rst),
        .bus      (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, fl, iv;
        logic [8:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm, pc4;
        logic        wbw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        e_haz, e_valid;
        logic [8:0]  e_ctrl;
        logic [31:0] e_d1, e_d2;
        logic [4:0]  e_rs, e_rt;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst              = v.rst;
        bus.stall        = v.stl;
        bus.flush        = v.fl;
        bus.id_valid     = v.iv;
        bus.id_ctrl      = v.ctrl;
        bus.id_rs        = v.rs;
        bus.id_rt        = v.rt;
        bus.id_rd        = v.rd;
        bus.id_readData1 = v.d1;
        bus.id_readData2 = v.d2;
        bus.id_imm       = v.imm;
        bus.id_pc4       = v.pc4;
        bus.wb_regWrite  = v.wbw;
        bus.wb_writeReg  = v.wbr;
        bus.wb_writeData = v.wbd;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("v%0d hazard_stall", idx), {31'd0, bus.hazard_stall}, {31'd0, v.e_haz});
        @(posedge clk);
        #1;
        check($sformatf("v%0d ex_valid", idx), {31'd0, bus.ex_valid}, {31'd0, v.e_valid});
        check($sformatf("v%0d ex_ctrl", idx), {23'd0, bus.ex_ctrl}, {23'd0, v.e_ctrl});
        check($sformatf("v%0d ex_readData1", idx), bus.ex_readData1, v.e_d1);
        check($sformatf("v%0d ex_readData2", idx), bus.ex_readData2, v.e_d2);
        check($sformatf("v%0d ex_rs", idx), {27'd0, bus.ex_rs}, {27'd0, v.e_rs});
        check($sformatf("v%0d ex_rt", idx), {27'd0, bus.ex_rt}, {27'd0, v.e_rt});
        check($sformatf("v%0d ex_pc4", idx), bus.ex_pc4, v.e_pc4);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        // Row layout:
        //   inputs: rst stl fl iv ctrl rs rt rd d1 d2 imm pc4 wbw wbr wbd
        //   expected: haz valid ctrl d1 d2 rs rt pc4
        // reset with every input nonzero
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,9'h1FF,5'd1,5'd2,5'd3,32'hAAAA,32'hBBBB,32'hCCCC,32'h1234,1'b1,5'd7,32'hDDDD, 1'b0,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd3,5'd4,5'd5,32'hFFFF0000,32'h12345678,32'h10,32'h104,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h001,32'hFFFF0000,32'h12345678,5'd3,5'd4,32'h104};
        // lw with rt=10, then a dependent add on rs=10: bubble, then re-presented
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,9'h027,5'd1,5'd10,5'd0,32'h100,32'h55,32'h0,32'h108,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h027,32'h100,32'h55,5'd1,5'd10,32'h108};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,9'h141,5'd10,5'd2,5'd3,32'h11,32'h22,32'h0,32'h10C,1'b0,5'd0,32'h0, 1'b1,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,9'h141,5'd10,5'd2,5'd3,32'h11,32'h22,32'h0,32'h10C,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h141,32'h11,32'h22,5'd10,5'd2,32'h10C};
        // lw with rt=0 followed by a reader of r0: no hazard
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,9'h027,5'd2,5'd0,5'd0,32'h200,32'h300,32'h0,32'h110,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h027,32'h200,32'h300,5'd2,5'd0,32'h110};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,9'h141,5'd0,5'd0,5'd1,32'h7,32'h8,32'h0,32'h114,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h141,32'h7,32'h8,5'd0,5'd0,32'h114};
        // stall for three edges, then stall together with flush
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b1,9'h001,5'd4,5'd5,5'd6,32'h99,32'h98,32'h0,32'h200,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h141,32'h7,32'h8,5'd0,5'd0,32'h114};
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,9'h001,5'd4,5'd5,5'd6,32'h99,32'h98,32'h0,32'h200,1'b0,5'd0,32'h0, 1'b0,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        // id_valid=0 loads a NOP control word
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,9'h1FF,5'd6,5'd7,5'd8,32'h42,32'h43,32'h0,32'h300,1'b0,5'd0,32'h0, 1'b0,1'b0,9'h000,32'h42,32'h43,5'd6,5'd7,32'h300};
        // WB write on load: rs=21 matches; r0 never bypassed; rt bypass
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd21,5'd3,5'd4,32'h0,32'h5,32'h0,32'h304,1'b1,5'd21,32'hFFFF0000, 1'b0,1'b1,9'h001,(BYP ? 32'hFFFF0000 : 32'h0),32'h5,5'd21,5'd3,32'h304};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd0,5'd3,5'd4,32'h0,32'h5,32'h0,32'h308,1'b1,5'd0,32'hFFFF0000, 1'b0,1'b1,9'h001,32'h0,32'h5,5'd0,5'd3,32'h308};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd1,5'd10,5'd2,32'h61,32'h62,32'h0,32'h30C,1'b1,5'd10,32'h0000ABCD, 1'b0,1'b1,9'h001,32'h61,(BYP ? 32'h0000ABCD : 32'h62),5'd1,5'd10,32'h30C};
        // WB refresh during stall: rt, then a non-writing WB, then rs
        vecs[15] = '{1'b0,1'b1,1'b0,1'b1,9'h1FF,5'd9,5'd9,5'd9,32'h1,32'h2,32'h0,32'h400,1'b1,5'd10,32'h0000FFFF, 1'b0,1'b1,9'h001,32'h61,(BYP ? 32'h0000FFFF : 32'h62),5'd1,5'd10,32'h30C};
        vecs[16] = '{1'b0,1'b1,1'b0,1'b1,9'h1FF,5'd9,5'd9,5'd9,32'h1,32'h2,32'h0,32'h400,1'b0,5'd1,32'hDEAD, 1'b0,1'b1,9'h001,32'h61,(BYP ? 32'h0000FFFF : 32'h62),5'd1,5'd10,32'h30C};
        vecs[17] = '{1'b0,1'b1,1'b0,1'b1,9'h1FF,5'd9,5'd9,5'd9,32'h1,32'h2,32'h0,32'h400,1'b1,5'd1,32'h77, 1'b0,1'b1,9'h001,(BYP ? 32'h77 : 32'h61),(BYP ? 32'h0000FFFF : 32'h62),5'd1,5'd10,32'h30C};
        // lw in EX, hazard raised while stalled (stall wins), then flush with hazard
        vecs[18] = '{1'b0,1'b0,1'b0,1'b1,9'h027,5'd2,5'd9,5'd0,32'hA,32'hB,32'h0,32'h500,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h027,32'hA,32'hB,5'd2,5'd9,32'h500};
        vecs[19] = '{1'b0,1'b1,1'b0,1'b1,9'h001,5'd9,5'd3,5'd4,32'hC,32'hD,32'h0,32'h504,1'b0,5'd0,32'h0, 1'b1,1'b1,9'h027,32'hA,32'hB,5'd2,5'd9,32'h500};
        vecs[20] = '{1'b0,1'b0,1'b1,1'b1,9'h001,5'd9,5'd3,5'd4,32'hC,32'hD,32'h0,32'h504,1'b0,5'd0,32'h0, 1'b0,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        // reset while stalled clears everything
        vecs[21] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd4,5'd5,5'd6,32'h33,32'h44,32'h0,32'h600,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h001,32'h33,32'h44,5'd4,5'd5,32'h600};
        vecs[22] = '{1'b1,1'b1,1'b0,1'b1,9'h001,5'd4,5'd5,5'd6,32'h33,32'h44,32'h0,32'h600,1'b0,5'd0,32'h0, 1'b0,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        // hazard through id_rt
        vecs[23] = '{1'b0,1'b0,1'b0,1'b1,9'h027,5'd0,5'd6,5'd0,32'h1,32'h2,32'h0,32'h700,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h027,32'h1,32'h2,5'd0,5'd6,32'h700};
        vecs[24] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd1,5'd6,5'd2,32'h3,32'h4,32'h0,32'h704,1'b0,5'd0,32'h0, 1'b1,1'b0,9'h000,32'h0,32'h0,5'd0,5'd0,32'h0};
        vecs[25] = '{1'b0,1'b0,1'b0,1'b1,9'h001,5'd1,5'd6,5'd2,32'h3,32'h4,32'h0,32'h704,1'b0,5'd0,32'h0, 1'b0,1'b1,9'h001,32'h3,32'h4,5'd1,5'd6,32'h704};

        for (int i = 0; i < 26; i++) apply(i, vecs[i]);

        // Hand sequence: a load in EX does not stall an ID slot that holds no valid instruction
        v = vecs[18];
        apply(100, v);
        @(negedge clk);
        bus.id_valid = 1'b0;
        bus.id_rs    = 5'd9;
        bus.id_rt    = 5'd9;
        #1;
        check("seq id_valid=0 no hazard", {31'd0, bus.hazard_stall}, 32'd0);
        @(posedge clk);
        #1;
        check("seq invalid load ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("seq invalid load ex_ctrl", {23'd0, bus.ex_ctrl}, 32'd0);
        // The slot that was loaded is a NOP, so a following reader of r9 does not stall
        @(negedge clk);
        bus.id_valid = 1'b1;
        #1;
        check("seq after nop no hazard", {31'd0, bus.hazard_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
